// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
// Owns the PC and issues one instruction-memory read per cycle while there is room.
// The memory has a registered output with a 1-cycle read latency. Returned words
// are stored with their PC in a DEPTH-entry FIFO. The FIFO feeds decode through a
// valid/ready handshake. A redirect flushes the FIFO, drops any in-flight read and
// restarts fetch at the new PC.
//
// Ports:
//   i_clk, i_reset               clock, synchronous active-high reset
//   o_imem_addr, o_imem_read     read request to instruction memory
//   i_imem_data                  read data, valid the cycle after o_imem_read
//   i_redirect, i_redirect_pc    flush and restart fetch at i_redirect_pc
//   o_valid, o_instr, o_pc       head entry presented to decode
//   i_ready                      decode accepts head when o_valid & i_ready
//   o_count                      FIFO occupancy
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    output logic [ADDR_W-1:0]          o_imem_addr,
    output logic                       o_imem_read,
    input  logic [XLEN-1:0]            i_imem_data,
    input  logic                       i_redirect,
    input  logic [XLEN-1:0]            i_redirect_pc,
    output logic                       o_valid,
    output logic [XLEN-1:0]            o_instr,
    output logic [XLEN-1:0]            o_pc,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OCC_W  = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

    logic [XLEN-1:0]  pc_r;
    logic             inflight_r;
    logic [XLEN-1:0]  inflight_pc_r;
    logic [XLEN-1:0]  pc_mem_r    [DEPTH];
    logic [XLEN-1:0]  instr_mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic [OCC_W-1:0] occupancy_s;
    logic             issue_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_s;

    // Occupancy counts the word returning this cycle so the FIFO can never overflow.
    assign occupancy_s = {1'b0, count_r} + OCC_W'(inflight_r);

    // Head is hidden during reset so the reset cycle itself shows an empty queue.
    assign valid_s = (count_r != {CNT_W{1'b0}}) & ~i_reset;

    // Issue / push / pop decisions; reset and redirect suppress all of them.
    always_comb begin
        issue_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (i_reset || i_redirect) begin
            issue_s = 1'b0;
            push_s  = 1'b0;
            pop_s   = 1'b0;
        end else begin
            issue_s = (occupancy_s < DEPTH_C);
            push_s  = inflight_r;
            pop_s   = valid_s & i_ready;
        end
    end

    // PC, in-flight tracking and FIFO pointer/count state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {XLEN{1'b0}};
            rd_ptr_r      <= {PTR_W{1'b0}};
            wr_ptr_r      <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else if (i_redirect) begin
            // Flush: the word returning now belongs to the old stream and is dropped.
            pc_r       <= i_redirect_pc;
            inflight_r <= 1'b0;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r          <= pc_r + XLEN'(3'd4);
                inflight_pc_r <= pc_r;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // FIFO storage; entries need no reset because the head is only shown when valid.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]    <= inflight_pc_r;
            instr_mem_r[wr_ptr_r] <= i_imem_data;
        end
    end

    // Head presentation; zero when empty so idle outputs are deterministic.
    always_comb begin
        o_pc    = {XLEN{1'b0}};
        o_instr = {XLEN{1'b0}};
        if (valid_s) begin
            o_pc    = pc_mem_r[rd_ptr_r];
            o_instr = instr_mem_r[rd_ptr_r];
        end else begin
            o_pc    = {XLEN{1'b0}};
            o_instr = {XLEN{1'b0}};
        end
    end

    assign o_valid     = valid_s;
    assign o_count     = count_r;
    assign o_imem_read = issue_s;
    assign o_imem_addr = pc_r[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a DEPTH=4 instance for the main scenarios and a
// DEPTH=2 instance for a randomised back-pressure run.
module tb_fetch_queue;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance signals
    logic        i_reset, i_redirect, i_ready;
    logic [31:0] i_redirect_pc, imem_data;
    logic [7:0]  imem_addr;
    logic        imem_read, o_valid;
    logic [31:0] o_instr, o_pc;
    logic [2:0]  o_count;

    // DEPTH=2 instance signals
    logic        reset2, redirect2, ready2;
    logic [31:0] redirect_pc2, imem_data2;
    logic [7:0]  imem_addr2;
    logic        imem_read2, valid2;
    logic [31:0] instr2, pc2;
    logic [1:0]  count2;

    int passed = 0;
    int total  = 0;

    fetch_queue #(.XLEN(32), .ADDR_W(8), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .o_imem_addr(imem_addr), .o_imem_read(imem_read), .i_imem_data(imem_data),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_valid(o_valid), .o_instr(o_instr), .o_pc(o_pc),
        .i_ready(i_ready), .o_count(o_count)
    );

    fetch_queue #(.XLEN(32), .ADDR_W(8), .DEPTH(2), .RESET_PC(32'h0)) dut2 (
        .i_clk(clk), .i_reset(reset2),
        .o_imem_addr(imem_addr2), .o_imem_read(imem_read2), .i_imem_data(imem_data2),
        .i_redirect(redirect2), .i_redirect_pc(redirect_pc2),
        .o_valid(valid2), .o_instr(instr2), .o_pc(pc2),
        .i_ready(ready2), .o_count(count2)
    );

    // Instruction memory contents: four fixed words, then an address-tagged pattern.
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        case (a)
            8'h00:   mem_word = 32'h0000_0013;
            8'h04:   mem_word = 32'h0010_0093;
            8'h08:   mem_word = 32'h0020_0113;
            8'h0C:   mem_word = 32'h0030_0193;
            default: mem_word = {24'hA5C300, a};
        endcase
    endfunction

    // Registered-output memory models, 1-cycle read latency.
    always @(posedge clk) if (imem_read)  imem_data  <= mem_word(imem_addr);
    always @(posedge clk) if (imem_read2) imem_data2 <= mem_word(imem_addr2);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles, then release; returns at the start of cycle 0.
    task automatic do_reset(input logic rdy);
        i_reset = 1'b1; i_redirect = 1'b0; i_ready = rdy;
        next_cycle(); #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_count", o_count, 3'd0);
        check("rst_read",  imem_read, 1'b0);
        check("rst_pc",    o_pc, 32'h0);
        check("rst_instr", o_instr, 32'h0);
        next_cycle();
        i_reset = 1'b0;
        #1;
    endtask

    logic [31:0] exp2;
    int          acc2;

    initial begin
        i_reset = 1'b1; i_redirect = 1'b0; i_ready = 1'b0; i_redirect_pc = 32'h0;
        reset2 = 1'b1; redirect2 = 1'b0; ready2 = 1'b0; redirect_pc2 = 32'h0;
        imem_data = 32'h0; imem_data2 = 32'h0;

        // ---- Test 1: basic stream with ready held high
        do_reset(1'b1);
        check("t1_c0_read", imem_read, 1'b1);
        check("t1_c0_addr", imem_addr, 8'h00);
        check("t1_c0_valid", o_valid, 1'b0);
        next_cycle(); #1;
        check("t1_c1_addr", imem_addr, 8'h04);
        check("t1_c1_valid", o_valid, 1'b0);
        next_cycle(); #1;
        check("t1_c2_valid", o_valid, 1'b1);
        check("t1_c2_pc", o_pc, 32'h0);
        check("t1_c2_instr", o_instr, 32'h0000_0013);
        next_cycle(); #1;
        check("t1_c3_pc", o_pc, 32'h4);
        check("t1_c3_instr", o_instr, 32'h0010_0093);
        next_cycle(); #1;
        check("t1_c4_pc", o_pc, 32'h8);
        check("t1_c4_instr", o_instr, 32'h0020_0113);
        next_cycle(); #1;
        check("t1_c5_pc", o_pc, 32'hC);
        check("t1_c5_instr", o_instr, 32'h0030_0193);

        // ---- Test 2: back-pressure from reset, fill then drain
        do_reset(1'b0);
        check("t2_c0_addr", imem_addr, 8'h00);
        check("t2_c0_read", imem_read, 1'b1);
        next_cycle(); #1;
        check("t2_c1_addr", imem_addr, 8'h04);
        next_cycle(); #1;
        check("t2_c2_addr", imem_addr, 8'h08);
        check("t2_c2_count", o_count, 3'd1);
        next_cycle(); #1;
        check("t2_c3_addr", imem_addr, 8'h0C);
        check("t2_c3_read", imem_read, 1'b1);
        next_cycle(); #1;
        check("t2_c4_read", imem_read, 1'b0);
        check("t2_c4_count", o_count, 3'd3);
        next_cycle(); #1;
        check("t2_c5_read", imem_read, 1'b0);
        check("t2_c5_count", o_count, 3'd4);
        next_cycle();
        i_ready = 1'b1; #1;
        check("t2_c6_read", imem_read, 1'b0);
        check("t2_c6_pc", o_pc, 32'h0);
        next_cycle(); #1;
        check("t2_c7_pc", o_pc, 32'h4);
        check("t2_c7_read", imem_read, 1'b1);
        check("t2_c7_addr", imem_addr, 8'h10);
        next_cycle(); #1;
        check("t2_c8_pc", o_pc, 32'h8);
        check("t2_c8_count", o_count, 3'd2);
        next_cycle(); #1;
        check("t2_c9_pc", o_pc, 32'hC);
        next_cycle(); #1;
        check("t2_c10_pc", o_pc, 32'h10);
        check("t2_c10_instr", o_instr, 32'hA5C3_0010);

        // ---- Test 3: redirect to 0x40 in cycle 10 of a steady stream
        do_reset(1'b1);
        for (int c = 1; c <= 9; c++) next_cycle();
        #1;
        check("t3_c9_pc", o_pc, 32'h1C);
        next_cycle();
        i_redirect = 1'b1; i_redirect_pc = 32'h40; #1;
        check("t3_c10_read", imem_read, 1'b0);
        next_cycle();
        i_redirect = 1'b0; #1;
        check("t3_c11_read", imem_read, 1'b1);
        check("t3_c11_addr", imem_addr, 8'h40);
        check("t3_c11_valid", o_valid, 1'b0);
        next_cycle(); #1;
        check("t3_c12_valid", o_valid, 1'b0);
        check("t3_c12_addr", imem_addr, 8'h44);
        next_cycle(); #1;
        check("t3_c13_valid", o_valid, 1'b1);
        check("t3_c13_pc", o_pc, 32'h40);
        check("t3_c13_instr", o_instr, 32'hA5C3_0040);
        next_cycle(); #1;
        check("t3_c14_pc", o_pc, 32'h44);

        // ---- Test 4: redirect to 0xFC, address wraps but PC does not
        next_cycle();
        i_redirect = 1'b1; i_redirect_pc = 32'hFC; #1;
        check("t4_r_read", imem_read, 1'b0);
        next_cycle();
        i_redirect = 1'b0; #1;
        check("t4_addr_fc", imem_addr, 8'hFC);
        next_cycle(); #1;
        check("t4_addr_00", imem_addr, 8'h00);
        next_cycle(); #1;
        check("t4_pc_fc", o_pc, 32'hFC);
        check("t4_instr_fc", o_instr, 32'hA5C3_00FC);
        next_cycle(); #1;
        check("t4_pc_100", o_pc, 32'h100);
        check("t4_instr_100", o_instr, 32'h0000_0013);

        // ---- Test 6: one-cycle reset with count=3 and a read in flight
        do_reset(1'b0);
        for (int c = 1; c <= 4; c++) next_cycle();
        #1;
        check("t6_pre_count", o_count, 3'd3);
        i_reset = 1'b1; #1;
        check("t6_rst_read", imem_read, 1'b0);
        check("t6_rst_valid", o_valid, 1'b0);
        next_cycle();
        i_reset = 1'b0; #1;
        check("t6_c0_valid", o_valid, 1'b0);
        check("t6_c0_count", o_count, 3'd0);
        check("t6_c0_addr", imem_addr, 8'h00);
        next_cycle(); #1;
        check("t6_c1_valid", o_valid, 1'b0);
        next_cycle(); #1;
        check("t6_c2_valid", o_valid, 1'b1);
        check("t6_c2_pc", o_pc, 32'h0);
        check("t6_c2_instr", o_instr, 32'h0000_0013);

        // ---- Test 5: DEPTH=2 with random ready
        next_cycle(); next_cycle();
        reset2 = 1'b0;
        exp2 = 32'h0;
        acc2 = 0;
        for (int c = 0; c < 500; c++) begin
            ready2 = 1'($urandom_range(0, 1));
            #1;
            check("t5_count_bound", {63'd0, (count2 <= 2'd2)}, 64'd1);
            if (valid2 && ready2) begin
                check("t5_pc", pc2, exp2);
                check("t5_instr", instr2, mem_word(exp2[7:0]));
                exp2 = exp2 + 32'd4;
                acc2 = acc2 + 1;
            end
            next_cycle();
        end
        check("t5_progress", {63'd0, (acc2 >= 40)}, 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end replacing the bare PC register + instruction-memory read in the IF stage. Owns the PC, issues reads to the instruction memory (registered output, 1-cycle read latency), buffers returned instructions with their PC in a DEPTH-entry FIFO, and presents them to decode through a valid/ready handshake. Taken-branch redirects flush the queue and squash any in-flight read.

Parameters:
XLEN, 32, width of PC and instruction words
ADDR_W, 8, instruction-memory byte address bits driven on o_imem_addr
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 0, PC value loaded on reset

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
o_imem_addr  output  ADDR_W  read address, = pc[ADDR_W-1:0]
o_imem_read  output  1  read request; data returned on i_imem_data next cycle
i_imem_data  input  XLEN  instruction word, valid the cycle after o_imem_read=1
i_redirect  input  1  flush and restart fetch at i_redirect_pc
i_redirect_pc  input  XLEN  new fetch PC
o_valid  output  1  head entry valid
o_instr  output  XLEN  head instruction
o_pc  output  XLEN  PC of head instruction
i_ready  input  1  decode accepts head when o_valid & i_ready
o_count  output  clog2(DEPTH)+1  current FIFO occupancy (debug/perf)

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_reset.
- Reset: pc=RESET_PC; FIFO empty (rd_ptr=wr_ptr=0, count=0); inflight=0. Resulting outputs: o_valid=0, o_count=0, o_imem_read=0 during the reset cycle. o_instr/o_pc=0.
- State: pc, inflight flag (1 if a read was issued last cycle and not squashed), FIFO storage {pc, instr} x DEPTH, rd_ptr, wr_ptr, count.
- Issue: o_imem_read = ~i_reset & ~i_redirect & (count + inflight < DEPTH). On issue, pc <= pc + 4 (mod 2^XLEN), inflight <= 1, and the issued PC is captured in an inflight_pc register. Otherwise inflight <= 0.
- Return: if inflight=1 (and no redirect this cycle), push {inflight_pc, i_imem_data} at wr_ptr at the end of the cycle.
- Pop: fire = o_valid & i_ready & ~i_redirect advances rd_ptr.
- count <= count + push - pop. Simultaneous push and pop at any occupancy is legal and leaves count unchanged. Overflow is impossible by the issue rule. Pop while empty is ignored.
- Pointers wrap modulo DEPTH.
- o_valid = (count != 0). o_instr/o_pc are driven from the head entry, with no combinational path from i_imem_data.
- Latency: a read issued in cycle T returns data in T+1, and the entry is visible as o_valid in T+2. Steady-state throughput is 1 instr/cycle with i_ready held high.
- Redirect (cycle N, priority over issue/push/pop):
  - FIFO flushed (count=0), inflight cleared, the returning word in N discarded, pc <= i_redirect_pc.
  - Any handshake in cycle N is void; decode must discard it.
  - Read of i_redirect_pc issued in N+1; o_valid=1 with o_pc=i_redirect_pc in N+3.
  - Back-to-back redirects: the last one wins.
- i_reset mid-operation: same as reset. Any in-flight data is dropped.
- Misaligned i_redirect_pc is not checked; the low bits pass through to o_imem_addr unchanged.

Test Plan:
1. Release reset, i_ready=1, imem[0..3] = 0x00000013, 0x00100093, 0x00200113, 0x00300193:
   - o_imem_read=1, addr 0x00 in cycle 0.
   - o_valid=1, o_pc=0, o_instr=0x00000013 in cycle 2.
   - Then pc 4, 8, 12 on consecutive cycles.
2. i_ready=0 from reset:
   - Exactly 4 reads issued (addrs 0, 4, 8, 12); o_count reaches 4; o_imem_read stays 0.
   - Raise i_ready: entries drain in order pc 0, 4, 8, 12, and issue resumes at pc 16 in the cycle the first pop frees a slot.
3. Steady stream, i_redirect=1 with i_redirect_pc=0x40 in cycle 10:
   - o_imem_read=0 in cycle 10; read at addr 0x40 in cycle 11.
   - o_valid=0 in cycles 11-12; o_pc=0x40 valid in cycle 13.
   - No pre-redirect PC is ever presented after cycle 10.
4. Redirect to 0xFC with ADDR_W=8: addr 0xFC then 0x00; o_pc reports 0xFC then 0x100 (full XLEN PC increments, address bits wrap).
5. Toggle i_ready randomly 50% with DEPTH=2 for 500 cycles: the o_pc sequence is strictly +4 per accepted instruction, with no duplicates or drops; o_count never exceeds 2.
6. Assert i_reset for one cycle while o_count=3 and a read is in flight: next cycle o_valid=0 and o_count=0; the stream restarts from RESET_PC with o_valid in the 2nd cycle after reset release.
